// File: rtl/tmux_pkg.sv
// Shared constants for the registered one-hot mux: mode encodings and error counter sizing.
// No logic, no latency, no backpressure.
// Imported by tmux_n_reg and tmux_onehot_chk.
package tmux_pkg;

    localparam int TMUX_MODE_ANDOR = 0;
    localparam int TMUX_MODE_PRIO  = 1;

    localparam int             ERR_CNT_W   = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/tmux_onehot_chk.sv
// Classifies a select vector as empty or multi-hot (one-hot when neither flag is set).
// Latency: purely combinational.
// Backpressure: none.
module tmux_onehot_chk
    import tmux_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] vec,
    output logic         is_zero,
    output logic         is_multi
);

    // Clearing the lowest set bit leaves something only when two or more bits were set.
    logic [N-1:0] low_cleared;

    assign low_cleared = vec & (vec - N'(1));
    assign is_zero     = ~|vec;
    assign is_multi    = |low_cleared;

endmodule

// File: rtl/tmux_n_reg.sv
// N-channel one-hot select mux with a registered output and valid/ready handshake; TMUX_ONEHOT_CHECK_EN adds sel_err/err_cnt.
// Latency: 1 cycle from accept to out_valid/result.
// Backpressure: in_ready = ~out_valid | out_ready; output register holds while stalled.
module tmux_n_reg
    import tmux_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int N        = 4,
    parameter int PRIORITY = TMUX_MODE_ANDOR
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         sel,
    input  logic [N*WIDTH-1:0]   src,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic                 sel_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic             accept;
    logic [WIDTH-1:0] mux_dat;

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    generate
        if (PRIORITY == TMUX_MODE_PRIO) begin : g_prio
            // Walk from the top down so the lowest asserted index is the last writer.
            always_comb begin
                mux_dat = '0;
                for (int i = N - 1; i >= 0; i--) begin
                    if (sel[i]) begin
                        mux_dat = src[i*WIDTH +: WIDTH];
                    end
                end
            end
        end else begin : g_andor
            always_comb begin
                mux_dat = '0;
                for (int i = 0; i < N; i++) begin
                    mux_dat = mux_dat | ({WIDTH{sel[i]}} & src[i*WIDTH +: WIDTH]);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            result    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            result    <= mux_dat;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef TMUX_ONEHOT_CHECK_EN
    logic                 sel_zero;
    logic                 sel_multi;
    logic                 sel_bad;
    logic                 sel_err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    tmux_onehot_chk #(
        .N (N)
    ) u_onehot_chk (
        .vec      (sel),
        .is_zero  (sel_zero),
        .is_multi (sel_multi)
    );

    assign sel_bad = sel_zero | sel_multi;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sel_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else if (accept) begin
            sel_err_q <= sel_bad;
            if (sel_bad && (err_cnt_q != ERR_CNT_MAX)) begin
                err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
            end
        end
    end

    assign sel_err = sel_err_q;
    assign err_cnt = err_cnt_q;
`else
    assign sel_err = 1'b0;
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_tmux_n_reg.sv
// Scoreboard bench for tmux_n_reg: AND-OR and priority instances share one stimulus stream.
// Expected values are pushed on accept and compared when the output transfers.
module tb_tmux_n_reg;

    localparam int W  = 32;
    localparam int NC = 4;

    typedef struct {
        logic [W-1:0] andor;
        logic [W-1:0] prio;
        logic         err;
        logic [7:0]   cnt;
    } sb_ent_t;

    logic          clk;
    logic          resetn;
    logic          in_valid;
    logic          in_ready;
    logic          in_ready_p;
    logic [NC-1:0] sel;
    logic [NC*W-1:0] src;
    logic          out_valid;
    logic          out_valid_p;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [W-1:0]  result_p;
    logic          sel_err;
    logic          sel_err_p;
    logic [7:0]    err_cnt;
    logic [7:0]    err_cnt_p;

    int      checks   = 0;
    int      failures = 0;
    int      model_cnt = 0;
    sb_ent_t sb_q[$];

    tmux_n_reg #(.WIDTH(W), .N(NC), .PRIORITY(0)) u_dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .src       (src),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .sel_err   (sel_err),
        .err_cnt   (err_cnt)
    );

    tmux_n_reg #(.WIDTH(W), .N(NC), .PRIORITY(1)) u_dut_prio (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready_p),
        .sel       (sel),
        .src       (src),
        .out_valid (out_valid_p),
        .out_ready (out_ready),
        .result    (result_p),
        .sel_err   (sel_err_p),
        .err_cnt   (err_cnt_p)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_andor(input logic [NC-1:0] s, input logic [NC*W-1:0] d);
        logic [W-1:0] r = '0;
        for (int i = 0; i < NC; i++)
            if (s[i]) r = r | d[i*W +: W];
        return r;
    endfunction

    function automatic logic [W-1:0] ref_prio(input logic [NC-1:0] s, input logic [NC*W-1:0] d);
        for (int i = 0; i < NC; i++)
            if (s[i]) return d[i*W +: W];
        return '0;
    endfunction

    function automatic logic ref_err(input logic [NC-1:0] s);
`ifdef TMUX_ONEHOT_CHECK_EN
        return ($countones(s) != 1);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [NC*W-1:0] pack4(input logic [W-1:0] a0, input logic [W-1:0] a1,
                                              input logic [W-1:0] a2, input logic [W-1:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    // Monitor: compare the transferring output first, then record a new accept.
    always @(negedge clk) begin
        if (!resetn) begin
            sb_q.delete();
            model_cnt = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_out", 32'd1, 32'd0);
                end else begin
                    sb_ent_t e;
                    e = sb_q.pop_front();
                    check("sb_result_andor", result, e.andor);
                    check("sb_result_prio", result_p, e.prio);
                    check("sb_sel_err", {31'd0, sel_err}, {31'd0, e.err});
                    check("sb_err_cnt", {24'd0, err_cnt}, {24'd0, e.cnt});
                    check("sb_valid_prio", {31'd0, out_valid_p}, 32'd1);
                end
            end
            if (in_valid && in_ready) begin
                sb_ent_t e;
                e.andor = ref_andor(sel, src);
                e.prio  = ref_prio(sel, src);
                e.err   = ref_err(sel);
                if (e.err && model_cnt < 255) model_cnt++;
                e.cnt   = 8'(model_cnt);
                sb_q.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seen;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sel       = '0;
        src       = '0;

        #3;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_sel_err", {31'd0, sel_err}, 32'd0);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        #9 resetn = 1'b1;
        step();
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Basic single transfer
        in_valid = 1'b1; out_ready = 1'b1; sel = 4'b0100;
        src = pack4(32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0);
        step();
        in_valid = 1'b0;
        check("basic_result", result, 32'hDEAD_BEEF);
        check("basic_valid", {31'd0, out_valid}, 32'd1);
        check("basic_sel_err", {31'd0, sel_err}, 32'd0);

        // Back-pressure: second item waits behind a stalled first item
        in_valid = 1'b1; sel = 4'b0001;
        src = pack4(32'h1111_1111, 32'h0, 32'h0, 32'h0);
        step();
        out_ready = 1'b0;
        src = pack4(32'h2222_2222, 32'h0, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_result", result, 32'h1111_1111);
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            step();
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("bp_release_result", result, 32'h2222_2222);
        check("bp_release_valid", {31'd0, out_valid}, 32'd1);

        // Multi-hot select: AND-OR merges, priority takes the lowest
        in_valid = 1'b1; sel = 4'b0011;
        src = pack4(32'h0000_00F0, 32'h0000_000F, 32'h5555_5555, 32'hAAAA_AAAA);
        step();
        in_valid = 1'b0;
        check("multi_andor", result, 32'h0000_00FF);
        check("multi_prio", result_p, 32'h0000_00F0);
        check("multi_sel_err", {31'd0, sel_err}, {31'd0, ref_err(4'b0011)});
        check("multi_err_cnt", {24'd0, err_cnt}, 32'(model_cnt));

        // Empty select, repeated past counter saturation
        in_valid = 1'b1; sel = 4'b0000;
        for (int k = 0; k < 300; k++) begin
            src = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        in_valid = 1'b0;
        check("zero_result", result, 32'd0);
        check("zero_result_prio", result_p, 32'd0);
        check("zero_sel_err", {31'd0, sel_err}, {31'd0, ref_err(4'b0000)});
`ifdef TMUX_ONEHOT_CHECK_EN
        check("sat_err_cnt", {24'd0, err_cnt}, 32'd255);
`else
        check("sat_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif

        // Streaming: 8 back-to-back accepts, no bubbles
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            sel = 4'b0001 << (k % 4);
            src = {$urandom, $urandom, $urandom, $urandom};
            step();
            if (out_valid) seen++;
        end
        in_valid = 1'b0;
        check("stream_valid_cycles", 32'(seen), 32'd8);
        step();
        check("stream_drained", {31'd0, out_valid}, 32'd0);

        // Reset while stalled with valid data
        in_valid = 1'b1; out_ready = 1'b0; sel = 4'b1000;
        src = pack4(32'h0, 32'h0, 32'h0, 32'h7777_7777);
        step();
        in_valid = 1'b0;
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_result", result, 32'd0);
        check("mid_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_sel_err", {31'd0, sel_err}, 32'd0);
        #4 resetn = 1'b1;

        // Post-reset transfer still works and the scoreboard is fully drained
        out_ready = 1'b1;
        step();
        in_valid = 1'b1; sel = 4'b0010;
        src = pack4(32'h0, 32'h1234_5678, 32'h0, 32'h0);
        step();
        in_valid = 1'b0;
        check("post_rst_result", result, 32'h1234_5678);
        step();
        step();
        check("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
